approx_adder_error_monitor: RTL and testbench
=============================================

Name: approx_adder_error_monitor

Overview:
Response-side companion to the approximate parallel-prefix adders. It takes operand/result tuples from an approximate adder, such as the 16-bit Ladner-Fischer K8 variant, and computes the exact WIDTH-bit sum. Over a programmable window of samples it accumulates error statistics (error count, summed error distance, maximum error distance) and returns one report through a valid/ready handshake. It is synthesizable and sits beside the adder under test in characterization harnesses and on-FPGA accuracy runs.

Parameters:
WIDTH, 16, adder operand and sum width
CNT_W, 32, width of window length, sample counter and error counter
ACC_W, 48, width of the summed error-distance accumulator

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that opens a window; honoured only in IDLE
win_len  input  CNT_W  number of samples in the window, latched on an accepted start
in_valid  input  1  sample tuple valid
in_ready  output  1  monitor accepts a sample
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in
in_sum  input  WIDTH  approximate sum under test (no carry-out)
busy  output  1  high in any state other than IDLE
rpt_valid  output  1  report valid
rpt_ready  input  1  report consumer ready
rpt_samples  output  CNT_W  samples accepted in the window
rpt_err_count  output  CNT_W  samples with a nonzero error distance
rpt_sum_ed  output  ACC_W  sum of error distances, saturating
rpt_max_ed  output  WIDTH  maximum error distance

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Counters, accumulators and pipeline valids clear. A reset asserted mid-window discards the window.
- Sample transfer: a sample is accepted when in_valid && in_ready. in_ready = (state==RUN) && (accepted < win_len_q), and it is driven from registers.
- Error computation:
  - exact = (in_a + in_b + in_cin) mod 2^WIDTH.
  - ED = |exact - in_sum|, computed in WIDTH+1 bits and returned as WIDTH bits unsigned.
  - Wrap-around is not corrected: exact 0x0000 against approx 0xFFFF gives ED 0xFFFF.
- Pipeline:
  - Stage 1 registers exact and in_sum.
  - Stage 2 computes ED and updates the statistics.
  - An accepted sample is reflected in the statistics 2 cycles after acceptance. Full throughput is 1 sample per cycle.
- Statistics update per sample:
  - samples += 1.
  - If ED != 0: err_count += 1.
  - sum_ed += ED, saturating at 2^ACC_W-1.
  - max_ed = max(max_ed, ED).
- FSM states:
  - IDLE: on start, latch win_len, clear all statistics, and go to RUN. If win_len==0, go to DRAIN instead.
  - RUN: accept samples. When the accepted count reaches win_len_q, go to DRAIN. Gaps in in_valid are allowed.
  - DRAIN: wait until both pipeline stages are empty, then go to REPORT.
  - REPORT: rpt_valid=1. All rpt_* outputs are registered and held stable until rpt_ready. On rpt_valid && rpt_ready, go to IDLE and drop rpt_valid in the next cycle.
- rpt_* outputs keep the last report values in IDLE. They clear only on reset or on the next start.
- start outside IDLE is ignored. start and rst together: rst wins.
- win_len==0: a zero report (samples 0, err 0, sum 0, max 0) asserts rpt_valid 2 cycles after start.

Decomposition:
- Shared package `axppa_mon_pkg`: FSM state enum (IDLE, RUN, DRAIN, REPORT) and default width constants.
- Sub-module `ed_calc`: a 2-stage pipe computing the exact sum and ED, with a valid passed through.
- The top level holds the FSM, counters, accumulators and report registers.

Test Plan:
- Basic window: win_len=3; samples (10,10,0,sum 20), (98,10,0,sum 100), (100,20,0,sum 120). Required report: samples 3, err_count 1, sum_ed 8, max_ed 8.
- Wrap-around: win_len=2; samples (0xFFFF,1,0,sum 0x0000) and (0xFFFF,1,0,sum 0xFFFF). Required report: samples 2, err_count 1, sum_ed 65535, max_ed 0xFFFF.
- Throughput and gaps: win_len=4 with in_valid toggling 1,0,1,1,0,1 and exact sums everywhere. Required behaviour: in_ready drops after the 4th accept; report samples 4, err_count 0.
- Backpressure: rpt_ready held low for 5 cycles. Required behaviour: rpt_valid and all rpt_* stay stable; handshake on the 6th cycle; IDLE the next cycle with busy=0.
- Zero window and ignored start: start with win_len=0 gives an all-zero report 2 cycles later. A start pulsed during RUN of a win_len=3 window leaves win_len_q unchanged.
- Reset mid-RUN: rst after 1 of 3 samples. Required behaviour: the next cycle has in_ready=0, busy=0, rpt_* all 0; a new window then reports only the new samples.

Source files
------------

// File: rtl/axppa_mon_pkg.sv
// Shared definitions for the approximate-adder error monitor.
// Holds the monitor FSM state encoding and the default widths used by the
// top level and the error-distance pipe.
package axppa_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;

endpackage

// File: rtl/ed_calc.sv
// Two-stage error-distance pipe.
// Stage 1 registers the exact sum (a + b + cin, truncated to WIDTH bits) next
// to the approximate sum. Stage 2 registers |exact - approx|, computed in
// WIDTH+1 bits so the sign is visible, with no wrap-around correction.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_vld           sample accepted this cycle
//   i_a, i_b, i_cin operands and carry-in
//   i_sum           approximate sum under test
//   s1_vld          stage 1 holds a sample
//   o_vld, o_ed     stage 2 holds a sample / its error distance
module ed_calc
  import axppa_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_sum,
  output logic             s1_vld,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_ed
);

  logic             vld1_q, vld1_d;
  logic [WIDTH-1:0] exact_q, exact_d;
  logic [WIDTH-1:0] apx_q, apx_d;
  logic             vld2_q, vld2_d;
  logic [WIDTH-1:0] ed_q, ed_d;
  logic [WIDTH:0]   diff;

  always_comb begin
    vld1_d  = i_vld;
    exact_d = i_a + i_b + WIDTH'(i_cin);
    apx_d   = i_sum;
    // Signed difference in WIDTH+1 bits; negate when exact < approx.
    diff    = {1'b0, exact_q} - {1'b0, apx_q};
    vld2_d  = vld1_q;
    ed_d    = diff[WIDTH] ? (~diff[WIDTH-1:0] + WIDTH'(1)) : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      exact_q <= '0;
      apx_q   <= '0;
      vld2_q  <= 1'b0;
      ed_q    <= '0;
    end else begin
      vld1_q  <= vld1_d;
      exact_q <= exact_d;
      apx_q   <= apx_d;
      vld2_q  <= vld2_d;
      ed_q    <= ed_d;
    end
  end

  assign s1_vld = vld1_q;
  assign o_vld  = vld2_q;
  assign o_ed   = ed_q;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Error monitor for approximate adders.
// Accepts (a, b, cin, approx_sum) tuples over a window of win_len samples,
// computes the exact sum and error distance (ED) in a 2-stage pipe, and
// accumulates sample count, error count, saturating ED sum and max ED. The
// finished report is presented through a valid/ready handshake and is kept
// on rpt_* afterwards until reset or the next accepted start.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, win_len        open a window (IDLE only), window length
//   in_valid/in_ready     sample handshake; in_a, in_b, in_cin, in_sum
//   busy                  FSM is not in IDLE
//   rpt_valid/rpt_ready   report handshake
//   rpt_samples, rpt_err_count, rpt_sum_ed, rpt_max_ed   report fields
module approx_adder_error_monitor
  import axppa_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_sum,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_samples,
  output logic [CNT_W-1:0] rpt_err_count,
  output logic [ACC_W-1:0] rpt_sum_ed,
  output logic [WIDTH-1:0] rpt_max_ed
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] acc_q, acc_d;        // samples accepted in this window
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] r_samples_q, r_samples_d;
  logic [CNT_W-1:0] r_err_q, r_err_d;
  logic [ACC_W-1:0] r_sum_q, r_sum_d;
  logic [WIDTH-1:0] r_max_q, r_max_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             s1_vld, ed_vld;
  logic [WIDTH-1:0] ed;
  logic [ACC_W:0]   sum_ext;

  assign accept = in_valid && in_ready_q;

  ed_calc #(.WIDTH(WIDTH)) u_ed_calc (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (accept),
    .i_a    (in_a),
    .i_b    (in_b),
    .i_cin  (in_cin),
    .i_sum  (in_sum),
    .s1_vld (s1_vld),
    .o_vld  (ed_vld),
    .o_ed   (ed)
  );

  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    acc_d       = acc_q;
    samples_d   = samples_q;
    err_d       = err_q;
    sum_d       = sum_q;
    max_d       = max_q;
    r_samples_d = r_samples_q;
    r_err_d     = r_err_q;
    r_sum_d     = r_sum_q;
    r_max_d     = r_max_q;
    rpt_valid_d = rpt_valid_q;
    sum_ext     = {1'b0, sum_q} + (ACC_W+1)'(ed);

    // Statistics follow the pipe output regardless of state; the pipe is
    // only fed in RUN and is empty again before REPORT.
    if (ed_vld) begin
      samples_d = samples_q + CNT_W'(1);
      if (ed != '0) err_d = err_q + CNT_W'(1);
      sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (ed > max_q) max_d = ed;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          win_len_d   = win_len;
          acc_d       = '0;
          samples_d   = '0;
          err_d       = '0;
          sum_d       = '0;
          max_d       = '0;
          r_samples_d = '0;
          r_err_d     = '0;
          r_sum_d     = '0;
          r_max_d     = '0;
          state_d     = (win_len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_d == win_len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Both stages empty means the last sample has already been folded
        // into the statistics registers.
        if (!s1_vld && !ed_vld) begin
          state_d     = REPORT;
          r_samples_d = samples_q;
          r_err_d     = err_q;
          r_sum_d     = sum_q;
          r_max_d     = max_q;
          rpt_valid_d = 1'b1;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          state_d     = IDLE;
          rpt_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == RUN) && (acc_d < win_len_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_len_q   <= '0;
      acc_q       <= '0;
      samples_q   <= '0;
      err_q       <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      r_samples_q <= '0;
      r_err_q     <= '0;
      r_sum_q     <= '0;
      r_max_q     <= '0;
      rpt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      acc_q       <= acc_d;
      samples_q   <= samples_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      r_samples_q <= r_samples_d;
      r_err_q     <= r_err_d;
      r_sum_q     <= r_sum_d;
      r_max_q     <= r_max_d;
      rpt_valid_q <= rpt_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign rpt_valid     = rpt_valid_q;
  assign rpt_samples   = r_samples_q;
  assign rpt_err_count = r_err_q;
  assign rpt_sum_ed    = r_sum_q;
  assign rpt_max_ed    = r_max_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench for approx_adder_error_monitor: basic window, wrap-around,
// gapped throughput, report backpressure, zero window, ignored start and
// reset in the middle of a window.
module tb_approx_adder_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] win_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b, in_sum;
  logic        in_cin;
  logic        busy;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [31:0] rpt_samples, rpt_err_count;
  logic [47:0] rpt_sum_ed;
  logic [15:0] rpt_max_ed;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  approx_adder_error_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .win_len      (win_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cin       (in_cin),
    .in_sum       (in_sum),
    .busy         (busy),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_samples  (rpt_samples),
    .rpt_err_count(rpt_err_count),
    .rpt_sum_ed   (rpt_sum_ed),
    .rpt_max_ed   (rpt_max_ed)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] w);
    start   = 1'b1;
    win_len = w;
    step();
    start   = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [15:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_cin = c; in_sum = s;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_rpt();
    int n = 0;
    while (!rpt_valid && n < 50) begin
      step();
      n++;
    end
    chk("rpt_timeout", 64'(rpt_valid), 64'd1);
  endtask

  task automatic check_rpt(input string tag, input logic [31:0] s, input logic [31:0] e,
                           input logic [47:0] sum, input logic [15:0] mx);
    chk({tag, "_samples"}, 64'(rpt_samples), 64'(s));
    chk({tag, "_err"}, 64'(rpt_err_count), 64'(e));
    chk({tag, "_sum_ed"}, 64'(rpt_sum_ed), 64'(sum));
    chk({tag, "_max_ed"}, 64'(rpt_max_ed), 64'(mx));
  endtask

  task automatic ack();
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    chk("ack_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("ack_busy", 64'(busy), 64'd0);
  endtask

  logic [5:0] pat;

  initial begin
    rst = 1'b1; start = 1'b0; win_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sum = '0; rpt_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rpt_valid", 64'(rpt_valid), 64'd0);
    check_rpt("rst", 32'd0, 32'd0, 48'd0, 16'd0);
    rst = 1'b0;
    step();

    // Basic window: EDs 0, 8, 0
    do_start(32'd3);
    chk("basic_busy", 64'(busy), 64'd1);
    send(16'd10, 16'd10, 1'b0, 16'd20);
    send(16'd98, 16'd10, 1'b0, 16'd100);
    send(16'd100, 16'd20, 1'b0, 16'd120);
    chk("basic_ready_drop", 64'(in_ready), 64'd0);
    wait_rpt();
    check_rpt("basic", 32'd3, 32'd1, 48'd8, 16'd8);
    ack();
    check_rpt("basic_hold", 32'd3, 32'd1, 48'd8, 16'd8);

    // Wrap-around plus report backpressure
    do_start(32'd2);
    send(16'hFFFF, 16'd1, 1'b0, 16'h0000);
    send(16'hFFFF, 16'd1, 1'b0, 16'hFFFF);
    wait_rpt();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rpt_valid), 64'd1);
      check_rpt("bp", 32'd2, 32'd1, 48'd65535, 16'hFFFF);
      step();
    end
    chk("bp_valid6", 64'(rpt_valid), 64'd1);
    ack();
    check_rpt("wrap_hold", 32'd2, 32'd1, 48'd65535, 16'hFFFF);

    // Gapped throughput, all exact
    pat = 6'b101101;
    do_start(32'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      in_a = 16'(i * 100); in_b = 16'd7; in_cin = 1'b1;
      in_sum = 16'(i * 100 + 8);
      if (pat[i]) chk("tp_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    chk("tp_ready_drop", 64'(in_ready), 64'd0);
    wait_rpt();
    check_rpt("tp", 32'd4, 32'd0, 48'd0, 16'd0);
    ack();

    // Zero window: report two cycles after start
    do_start(32'd0);
    chk("zero_valid_c1", 64'(rpt_valid), 64'd0);
    chk("zero_busy", 64'(busy), 64'd1);
    step();
    chk("zero_valid_c2", 64'(rpt_valid), 64'd1);
    check_rpt("zero", 32'd0, 32'd0, 48'd0, 16'd0);
    ack();

    // start during RUN must not relatch win_len
    do_start(32'd3);
    send(16'd1, 16'd2, 1'b0, 16'd3);
    start = 1'b1; win_len = 32'd5;
    step();
    start = 1'b0;
    chk("ign_busy", 64'(busy), 64'd1);
    send(16'd1, 16'd2, 1'b0, 16'd4);
    send(16'd1, 16'd2, 1'b1, 16'd3);
    chk("ign_ready_drop", 64'(in_ready), 64'd0);
    wait_rpt();
    check_rpt("ign", 32'd3, 32'd2, 48'd2, 16'd1);
    ack();

    // Reset after 1 of 3 samples
    do_start(32'd3);
    send(16'd5, 16'd5, 1'b0, 16'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_in_ready", 64'(in_ready), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_rpt_valid", 64'(rpt_valid), 64'd0);
    check_rpt("mrst", 32'd0, 32'd0, 48'd0, 16'd0);
    step();
    do_start(32'd2);
    send(16'd1, 16'd1, 1'b0, 16'd2);
    send(16'd3, 16'd4, 1'b1, 16'd0);
    wait_rpt();
    check_rpt("post_rst", 32'd2, 32'd1, 48'd8, 16'd8);
    ack();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
